cnt1_arbiter: RTL and testbench
===============================

Name: cnt1_arbiter

Overview:
- Shares one cnt1 popcount pipeline among NUM_REQ vector sources; placed directly upstream of cnt1.
- Grants a requester for one whole vector (SUB_VECTOR_NO consecutive bus words). A vector is never interleaved with another source.
- Carries the granted requester ID through a DELAY-deep tag pipeline, so each cnt1 result can be matched to its source.

Parameters:
- NUM_REQ, 3, number of requesters.
- VECTOR_WIDTH, 920, bits per full vector.
- BUS_WIDTH, 128, bits per sub-vector word.
- SUB_VECTOR_NO, ceil(VECTOR_WIDTH/BUS_WIDTH) = 8, words per vector.
- DELAY, 4, cnt1 latency in shift-enabled cycles; must equal cnt1's internal DELAY.
- ID_WIDTH, max(1, clog2(NUM_REQ)), requester ID width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- i_Vector  in  NUM_REQ*BUS_WIDTH  packed requester words; requester k occupies [k*BUS_WIDTH +: BUS_WIDTH].
- i_Valid  in  NUM_REQ  per-requester word valid; also serves as the request.
- o_Ready  out  NUM_REQ  per-requester ready.
- o_Vector  out  BUS_WIDTH  word to cnt1 i_Vector.
- o_Valid  out  1  to cnt1 i_Valid.
- i_Ready  in  1  from cnt1 o_Ready.
- o_GrantId  out  ID_WIDTH  current grant owner; valid while o_Busy.
- o_Busy  out  1  high in BURST.
- o_CntId  out  ID_WIDTH  requester ID aligned with cnt1 o_Valid/o_Cnt.

Behaviour:
- Reset (async, rstn=0):
  - state IDLE, round-robin pointer r_Ptr=0, word counter 0, grant 0, tag pipeline cleared.
  - All outputs 0.
  - A reset mid-burst abandons the partial vector; cnt1 is reset by the same rstn.
- FSM IDLE:
  - o_Valid=0, o_Ready=0.
  - If any i_Valid bit is set, register a winner: search from r_Ptr upward and wrap modulo NUM_REQ; the first set bit wins. Next cycle: BURST, counter=0.
  - If no i_Valid bit is set, stay in IDLE.
  - There is exactly one arbitration bubble per vector.
- FSM BURST (owner g):
  - o_Vector = word g; o_Valid = i_Valid[g]; o_Ready[g] = i_Ready; every other o_Ready bit is 0.
  - A transfer is i_Valid[g] && i_Ready; each transfer increments the counter.
  - A transfer with counter == SUB_VECTOR_NO-1 does three things: counter -> 0, r_Ptr -> (g+1) mod NUM_REQ, state -> IDLE.
  - If the owner deasserts i_Valid mid-vector, the grant is held and o_Valid=0 bubbles pass. There is no timeout.
  - If i_Ready=0, all state holds and outputs are stable.
- Simultaneous requests: the round-robin order decides. Requests that arrive during BURST wait; they are not dropped.
- o_Busy=1 exactly in BURST. o_GrantId = g, or 0 in IDLE.
- Tag pipeline:
  - DELAY registers, shifted on i_Ready=1 only, matching cnt1 shift enables.
  - Input = g when o_Valid=1, else 0.
  - o_CntId = last stage, so it is valid whenever cnt1 o_Valid=1.
- Width rules:
  - The counter is clog2(SUB_VECTOR_NO) bits, minimum 1.
  - r_Ptr wraps explicitly at NUM_REQ-1 (non-power-of-2 NUM_REQ is legal).
- NUM_REQ=1: the block degenerates to a pass-through with the one-cycle bubble per vector; ID is always 0.

Optional Feature:
- Macro: CNT1_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index set i_Valid bit wins in IDLE; r_Ptr is not implemented or updated.
- Undefined (default): round-robin as described above.
- Grant atomicity, handshake and tag pipeline are identical in both modes.

Test Plan:
- Reset then idle: all i_Valid=0 for 20 cycles -> o_Valid=0, o_Busy=0, o_Ready=000.
- Single requester 1 streams 8 words, i_Ready=1:
  - o_Busy rises 1 cycle after i_Valid[1].
  - 8 words pass in order with o_GrantId=1.
  - o_Busy falls after word 7; o_CntId=1 on cnt1 o_Valid, 4 cycles after each word.
- All 3 requesters valid continuously, 3 vectors:
  - Grant order 0,1,2, then 0 again.
  - One bubble between vectors; no interleaving.
  - Under CNT1_ARB_FIXED_PRIO_EN, the order is 0,0,0.
- i_Ready toggles 1/0 during requester 2's burst:
  - Words advance only on i_Ready=1.
  - Tag pipeline and counter freeze when i_Ready=0.
  - The vector completes after exactly 8 transfers.
- Owner 0 drops i_Valid for 3 cycles after word 3 while requester 1 is valid:
  - Grant stays 0; o_Valid=0 for 3 cycles; words 4..7 follow.
  - Requester 1 is granted next.
- rstn pulsed low at word 5 of requester 2: outputs go to 0 immediately; after release, the next grant starts from requester 0.

Source files
------------

// File: rtl/cnt1_arbiter.sv
// cnt1_arbiter: shares one cnt1 popcount pipeline among NUM_REQ vector sources.
// A requester is granted for a whole vector of SUB_VECTOR_NO bus words, and
// vectors from different sources are never interleaved. The owner's ID travels
// through a DELAY-deep tag pipeline that shifts with cnt1, so o_CntId lines up
// with cnt1's result.
// Build option: define CNT1_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins. The default build uses round-robin arbitration.
module cnt1_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int VECTOR_WIDTH  = 920,
  parameter int BUS_WIDTH     = 128,
  parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int DELAY         = 4,
  parameter int ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] i_Vector,
  input  logic [NUM_REQ-1:0]           i_Valid,
  output logic [NUM_REQ-1:0]           o_Ready,
  output logic [BUS_WIDTH-1:0]         o_Vector,
  output logic                         o_Valid,
  input  logic                         i_Ready,
  output logic [ID_WIDTH-1:0]          o_GrantId,
  output logic                         o_Busy,
  output logic [ID_WIDTH-1:0]          o_CntId
);

  localparam int CNT_WIDTH = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(SUB_VECTOR_NO - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  word_cnt, word_cnt_n;
  logic [ID_WIDTH-1:0]   grant, grant_n;
  logic [ID_WIDTH-1:0]   winner;
  logic [BUS_WIDTH-1:0]  owner_word;
  logic                  owner_valid;
  logic                  any_req;
  logic                  xfer;
  logic [ID_WIDTH-1:0]   tag [DELAY];

`ifndef CNT1_ARB_FIXED_PRIO_EN
  logic [ID_WIDTH-1:0]   r_ptr, r_ptr_n;
`endif

  assign any_req = |i_Valid;

`ifdef CNT1_ARB_FIXED_PRIO_EN
  // Winner selection: the lowest-index requester wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path leaves it unassigned and infers a latch.
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_Valid[i]) winner = ID_WIDTH'(i);
    end
  end
`else
  // Winner selection: search upward from r_ptr with an explicit wrap, so a NUM_REQ that is not a power of 2 works.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_Valid[idx]) begin
        winner = ID_WIDTH'(idx);
        found  = 1'b1;
      end
    end
  end
`endif

  // Owner datapath: steer the granted source to cnt1 and return i_Ready to the owner only.
  always_comb begin
    owner_word  = '0;
    owner_valid = 1'b0;
    o_Ready     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (state == BURST && grant == ID_WIDTH'(k)) begin
        owner_word = i_Vector[k*BUS_WIDTH +: BUS_WIDTH];
        owner_valid = i_Valid[k];
        o_Ready[k]  = i_Ready;
      end
    end
  end

  assign o_Vector  = owner_word;
  assign o_Valid   = owner_valid;
  assign xfer      = owner_valid & i_Ready;
  assign o_Busy    = (state == BURST);
  assign o_GrantId = (state == BURST) ? grant : '0;
  assign o_CntId   = tag[DELAY-1];

  // Next-state logic: IDLE arbitrates (one bubble per vector), BURST counts the owner's transfers.
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    grant_n    = grant;
`ifndef CNT1_ARB_FIXED_PRIO_EN
    r_ptr_n    = r_ptr;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_n    = winner;
          word_cnt_n = '0;
          state_n    = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          if (word_cnt == LAST_WORD) begin
            word_cnt_n = '0;
            state_n    = IDLE;
`ifndef CNT1_ARB_FIXED_PRIO_EN
            r_ptr_n    = (grant == LAST_ID) ? '0 : grant + ID_WIDTH'(1);
`endif
          end else begin
            word_cnt_n = word_cnt + CNT_WIDTH'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register. An asynchronous reset abandons any partial vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      word_cnt <= '0;
      grant    <= '0;
`ifndef CNT1_ARB_FIXED_PRIO_EN
      r_ptr    <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      state    <= state_n;
      word_cnt <= word_cnt_n;
      grant    <= grant_n;
`ifndef CNT1_ARB_FIXED_PRIO_EN
      r_ptr    <= r_ptr_n;
`endif
    end
  end

  // Tag pipeline: shifts only on i_Ready, the same enable that cnt1 uses. A non-valid slot carries ID 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: this small register array is reset on purpose because o_CntId must read 0 right after reset.
      for (int i = 0; i < DELAY; i++) tag[i] <= '0;
    end else if (i_Ready) begin
      tag[0] <= o_Valid ? grant : '0;
      for (int i = 1; i < DELAY; i++) tag[i] <= tag[i-1];
    end
  end

endmodule

// File: tb/tb_cnt1_arbiter.sv
// Directed testbench for cnt1_arbiter using its default parameters
// (3 requesters, 128-bit words, 8 words per vector, 4-stage tag pipeline).
module tb_cnt1_arbiter;

  localparam int NR = 3;
  localparam int BW = 128;
`ifdef CNT1_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic [NR*BW-1:0] i_Vector;
  logic [NR-1:0]   i_Valid;
  logic [NR-1:0]   o_Ready;
  logic [BW-1:0]   o_Vector;
  logic            o_Valid;
  logic            i_Ready;
  logic [1:0]      o_GrantId;
  logic            o_Busy;
  logic [1:0]      o_CntId;

  int checks = 0;
  int errors = 0;
  int widx [NR];

  cnt1_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_Vector  (i_Vector),
    .i_Valid   (i_Valid),
    .o_Ready   (o_Ready),
    .o_Vector  (o_Vector),
    .o_Valid   (o_Valid),
    .i_Ready   (i_Ready),
    .o_GrantId (o_GrantId),
    .o_Busy    (o_Busy),
    .o_CntId   (o_CntId)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pattern(int k, int j);
    return {32'(k + 1), 64'hDEAD_BEEF_0123_4567, 32'(j)};
  endfunction

  // Each source presents its current word index.
  task automatic drive_words();
    for (int k = 0; k < NR; k++) i_Vector[k*BW +: BW] = pattern(k, widx[k]);
  endtask

  // Clock one edge; the sources step to their next word after a handshake.
  task automatic advance();
    logic [NR-1:0] xf;
    xf = o_Ready & i_Valid;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++)
      if (xf[k]) widx[k] = (widx[k] == 7) ? 0 : widx[k] + 1;
    drive_words();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) advance();
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_Valid = '0; i_Ready = 1'b1;
    for (int k = 0; k < NR; k++) widx[k] = 0;
    drive_words();
    #3;
    checks++;
    if ({o_Busy, o_Valid, o_Ready, o_GrantId, o_CntId} !== 9'd0 || o_Vector !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%0b valid=%0b ready=%b gid=%0d cntid=%0d vec=%h required all 0",
               o_Busy, o_Valid, o_Ready, o_GrantId, o_CntId, o_Vector);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({o_Busy, o_Valid, o_Ready} !== 5'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle=%0d busy=%0b valid=%0b ready=%b required 0/0/000",
                 c, o_Busy, o_Valid, o_Ready);
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int g;
    i_Valid = 3'b111;
    #1;
    for (int v = 0; v < 4; v++) begin
      g = FIXED ? 0 : (v % 3);
      checks++;
      if ({o_Busy, o_Valid, o_Ready} !== 5'b0) begin
        errors++;
        $display("FAIL rr_bubble vec=%0d busy=%0b valid=%0b ready=%b required 0/0/000",
                 v, o_Busy, o_Valid, o_Ready);
      end
      advance();
      for (int j = 0; j < 8; j++) begin
        checks++;
        if ({o_Busy, o_Valid, o_Ready, o_GrantId} !== {1'b1, 1'b1, 3'(1 << g), 2'(g)}) begin
          errors++;
          $display("FAIL rr_ctrl vec=%0d word=%0d busy=%0b valid=%0b ready=%b gid=%0d required gid=%0d",
                   v, j, o_Busy, o_Valid, o_Ready, o_GrantId, g);
        end
        checks++;
        if (o_Vector !== pattern(g, j)) begin
          errors++;
          $display("FAIL rr_word vec=%0d word=%0d got=%h required=%h", v, j, o_Vector, pattern(g, j));
        end
        advance();
      end
    end
    i_Valid = '0;
    #1;
    checks++;
    if (o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_end busy=%0b required 0", o_Busy);
    end
    idle(6);
  endtask

  task automatic test_single();
    i_Valid = 3'b010;
    #1;
    checks++;
    if ({o_Busy, o_Valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_bubble busy=%0b valid=%0b required 0/0", o_Busy, o_Valid);
    end
    advance();
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        checks++;
        if ({o_Busy, o_Valid, o_Ready, o_GrantId} !== {1'b1, 1'b1, 3'b010, 2'd1}) begin
          errors++;
          $display("FAIL single_ctrl word=%0d busy=%0b valid=%0b ready=%b gid=%0d required 1/1/010/1",
                   c, o_Busy, o_Valid, o_Ready, o_GrantId);
        end
        checks++;
        if (o_Vector !== pattern(1, c)) begin
          errors++;
          $display("FAIL single_word word=%0d got=%h required=%h", c, o_Vector, pattern(1, c));
        end
      end else if (c == 8) begin
        checks++;
        if ({o_Busy, o_Ready} !== 4'b0) begin
          errors++;
          $display("FAIL single_end busy=%0b ready=%b required 0/000", o_Busy, o_Ready);
        end
      end
      checks++;
      if (o_CntId !== ((c >= 4 && c <= 11) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL single_cntid cycle=%0d got=%0d required=%0d",
                 c, o_CntId, (c >= 4 && c <= 11) ? 1 : 0);
      end
      advance();
      if (c == 7) begin
        i_Valid = '0;
        #1;
      end
    end
  endtask

  task automatic test_ready_toggle();
    int  xfers;
    int  n2;
    logic rdy;
    xfers = 0; n2 = 0;
    i_Valid = 3'b100;
    #1;
    advance();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (xfers == 8) break;
      i_Ready = (cyc % 2 == 0);
      #1;
      checks++;
      if ({o_Busy, o_Valid, o_Ready, o_GrantId} !== {1'b1, 1'b1, (i_Ready ? 3'b100 : 3'b000), 2'd2}) begin
        errors++;
        $display("FAIL toggle_ctrl cycle=%0d busy=%0b valid=%0b ready=%b gid=%0d required gid=2",
                 cyc, o_Busy, o_Valid, o_Ready, o_GrantId);
      end
      checks++;
      if (o_Vector !== pattern(2, xfers)) begin
        errors++;
        $display("FAIL toggle_word cycle=%0d got=%h required=%h", cyc, o_Vector, pattern(2, xfers));
      end
      checks++;
      if (o_CntId !== ((n2 >= 4) ? 2'd2 : 2'd0)) begin
        errors++;
        $display("FAIL toggle_cntid cycle=%0d got=%0d required=%0d", cyc, o_CntId, (n2 >= 4) ? 2 : 0);
      end
      rdy = i_Ready;
      advance();
      if (rdy) begin
        xfers++;
        n2++;
        if (xfers == 8) begin
          i_Valid = '0;
          #1;
        end
      end
    end
    checks++;
    if (xfers !== 8 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_done transfers=%0d busy=%0b required 8/0", xfers, o_Busy);
    end
    i_Ready = 1'b1;
    idle(6);
  endtask

  task automatic test_owner_drop();
    int g2;
    g2 = FIXED ? 0 : 1;
    i_Valid = 3'b011;
    #1;
    advance();
    for (int j = 0; j < 8; j++) begin
      if (j == 4) begin
        i_Valid[0] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
          checks++;
          if ({o_Busy, o_Valid, o_Ready, o_GrantId} !== {1'b1, 1'b0, 3'b001, 2'd0}) begin
            errors++;
            $display("FAIL drop_hold cycle=%0d busy=%0b valid=%0b ready=%b gid=%0d required 1/0/001/0",
                     d, o_Busy, o_Valid, o_Ready, o_GrantId);
          end
          advance();
        end
        i_Valid[0] = 1'b1;
        #1;
      end
      checks++;
      if ({o_Busy, o_Valid, o_Ready, o_GrantId} !== {1'b1, 1'b1, 3'b001, 2'd0} || o_Vector !== pattern(0, j)) begin
        errors++;
        $display("FAIL drop_word word=%0d gid=%0d valid=%0b vec=%h required gid=0 vec=%h",
                 j, o_GrantId, o_Valid, o_Vector, pattern(0, j));
      end
      advance();
    end
    checks++;
    if (o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_bubble busy=%0b required 0", o_Busy);
    end
    advance();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if ({o_Busy, o_Valid, o_GrantId} !== {1'b1, 1'b1, 2'(g2)} || o_Vector !== pattern(g2, j)) begin
        errors++;
        $display("FAIL drop_next word=%0d gid=%0d vec=%h required gid=%0d vec=%h",
                 j, o_GrantId, o_Vector, g2, pattern(g2, j));
      end
      advance();
    end
    i_Valid = '0;
    #1;
    idle(6);
  endtask

  task automatic test_reset_mid();
    i_Valid = 3'b100;
    #1;
    advance();
    for (int j = 0; j < 5; j++) advance();
    checks++;
    if ({o_Busy, o_GrantId} !== 3'b110 || o_Vector !== pattern(2, 5)) begin
      errors++;
      $display("FAIL rst_pre busy=%0b gid=%0d vec=%h required 1/2 vec=%h",
               o_Busy, o_GrantId, o_Vector, pattern(2, 5));
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({o_Busy, o_Valid, o_Ready, o_GrantId, o_CntId} !== 9'd0 || o_Vector !== '0) begin
      errors++;
      $display("FAIL rst_async busy=%0b valid=%0b ready=%b gid=%0d cntid=%0d required all 0",
               o_Busy, o_Valid, o_Ready, o_GrantId, o_CntId);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({o_Busy, o_Valid, o_Ready, o_CntId} !== 7'd0) begin
      errors++;
      $display("FAIL rst_hold busy=%0b valid=%0b ready=%b cntid=%0d required all 0",
               o_Busy, o_Valid, o_Ready, o_CntId);
    end
    rstn = 1'b1;
    for (int k = 0; k < NR; k++) widx[k] = 0;
    i_Valid = 3'b111;
    drive_words();
    #1;
    checks++;
    if (o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_bubble busy=%0b required 0", o_Busy);
    end
    advance();
    checks++;
    if ({o_Busy, o_Valid, o_GrantId} !== {1'b1, 1'b1, 2'd0} || o_Vector !== pattern(0, 0)) begin
      errors++;
      $display("FAIL rst_regrant busy=%0b gid=%0d vec=%h required 1/0 vec=%h",
               o_Busy, o_GrantId, o_Vector, pattern(0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_ready_toggle();
    test_owner_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
